time_base_scaler: RTL and testbench
===================================

TIME_BASE_SCALER -- requirements
Module: time_base_scaler

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD_BITS, default 6, meaning width of the sample-period code.
REQ-002 SHALL have parameter SAMPLES_PER_DIVISION, default 10, meaning samples displayed per graticule division.
REQ-003 SHALL have parameter CLOCK_PERIOD_NS, default 10, meaning sample-clock period in ns per sample-period step.
REQ-004 SHALL have parameter TIME_PER_DIVISION_BITS, default 10, meaning width of the displayed mantissa.
REQ-005 SHALL derive localparam PRODUCT_BITS = SAMPLE_PERIOD_BITS + 1 + clog2(SAMPLES_PER_DIVISION*CLOCK_PERIOD_NS), not user-overridable.
REQ-006 SHALL have port clock, input, 1, single clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port samplePeriod, input, SAMPLE_PERIOD_BITS, period code; sample period = code+1 clocks.
REQ-009 SHALL have port start, input, 1, request conversion; sampled only when ready=1.
REQ-010 SHALL have port ready, output, 1, high only in IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when results update.
REQ-012 SHALL have port timePerDivision, output, TIME_PER_DIVISION_BITS, normalized mantissa.
REQ-013 SHALL have port unit, output, 2, 0=ns, 1=us, 2=ms, 3=s.
REQ-014 SHALL have port overflow, output, 1, mantissa saturated on last conversion.

Function
REQ-015 SHALL implement FSM states IDLE, MULTIPLY, NORMALIZE, DIVIDE, DONE.
REQ-016 IDLE: start=1 SHALL latch samplePeriod and go to MULTIPLY next edge; start=0 stays IDLE.
REQ-017 start while ready=0 SHALL be ignored; no queuing.
REQ-018 MULTIPLY: value <= (samplePeriod+1)*SAMPLES_PER_DIVISION*CLOCK_PERIOD_NS at PRODUCT_BITS, exact, no overflow; working unit <= 0; one cycle, then NORMALIZE.
REQ-019 NORMALIZE: value<1000 or working unit==3 SHALL go to DONE; else DIVIDE.
REQ-020 DIVIDE: bit-serial restoring divide of value by 1000, exactly PRODUCT_BITS cycles; quotient replaces value (remainder discarded, truncation); working unit increments; then NORMALIZE.
REQ-021 On entry to DONE: value fitting TIME_PER_DIVISION_BITS SHALL load into timePerDivision with overflow=0; else timePerDivision=all-ones, overflow=1; unit loads working unit.
REQ-022 done SHALL be high exactly the one cycle in DONE; DONE always returns to IDLE next edge.
REQ-023 Latency, start-sampled edge to done-high cycle, SHALL be 3 + k*(PRODUCT_BITS+1) cycles, k = divisions performed.
REQ-024 timePerDivision, unit, overflow SHALL hold between done pulses.
REQ-025 samplePeriod changes after the start edge SHALL not affect the running conversion.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, ready=1, done=0, timePerDivision=0, unit=0, overflow=0, internal value/counters=0, including mid-DIVIDE.
REQ-027 First start after reset deassertion SHALL be accepted on the first clock edge with start=1.

Structure
REQ-028 A shared package SHALL hold the unit encodings, divisor constant 1000, and FSM state encoding.
REQ-029 The serial divider SHALL be one sub-module, serial_const_divider (start/busy/quotient, width parameter, divisor parameter); everything else in time_base_scaler.

Verification
REQ-030 Defaults, samplePeriod=0, start -> done at cycle 3, timePerDivision=100, unit=0, overflow=0.
REQ-031 Defaults, samplePeriod=9 -> value 1000 -> done at cycle 18, timePerDivision=1, unit=1.
REQ-032 Defaults, samplePeriod=63 -> 6400 ns -> timePerDivision=6 (truncated), unit=1, done at cycle 18.
REQ-033 TIME_PER_DIVISION_BITS=8, samplePeriod=2 -> 300 ns -> timePerDivision=255, overflow=1, unit=0.
REQ-034 start pulse every cycle during a samplePeriod=9 conversion -> only one done; second conversion starts only after ready returns high.
REQ-035 reset asserted at cycle 8 of samplePeriod=9 conversion -> same-cycle ready=1, all outputs 0, no done until a new start.

Source files
------------

// File: rtl/time_base_scaler_pkg.sv
// Shared encodings for the time-base scaler: display units, the decade
// divisor and the conversion FSM states.
package time_base_scaler_pkg;

    localparam int DIVISOR = 1000;

    typedef enum logic [1:0] {
        UNIT_NS = 2'd0,
        UNIT_US = 2'd1,
        UNIT_MS = 2'd2,
        UNIT_S  = 2'd3
    } unit_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MULTIPLY  = 3'd1,
        S_NORMALIZE = 3'd2,
        S_DIVIDE    = 3'd3,
        S_DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/time_base_scaler_divider.sv
// Bit-serial restoring divider by a constant. The first quotient bit is
// produced on the start edge, so a full divide takes exactly WIDTH edges.
module serial_const_divider #(
    parameter int WIDTH   = 14,
    parameter int DIVISOR = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic [WIDTH-1:0] quotient
);

    localparam int RW    = $clog2(DIVISOR);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [RW-1:0]    rem, src_rem, step_rem;
    logic [WIDTH-1:0] src_q, step_q;
    logic [RW:0]      trial;
    logic [CNT_W-1:0] cnt;

    // quotient doubles as the dividend shift register while busy
    always_comb begin
        src_rem = start ? '0 : rem;
        src_q   = start ? dividend : quotient;
        trial   = {src_rem, src_q[WIDTH-1]};
        if (trial >= (RW+1)'(DIVISOR)) begin
            step_rem = RW'(trial - (RW+1)'(DIVISOR));
            step_q   = {src_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = RW'(trial);
            step_q   = {src_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            quotient <= '0;
            cnt      <= '0;
        end else if (start) begin
            rem      <= step_rem;
            quotient <= step_q;
            cnt      <= CNT_W'(WIDTH - 1);
        end else if (cnt != '0) begin
            rem      <= step_rem;
            quotient <= step_q;
            cnt      <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/time_base_scaler.sv
// Converts a sample-period code into a time-per-division mantissa and unit,
// dividing by 1000 serially until the value drops below 1000 or reaches seconds.
module time_base_scaler
    import time_base_scaler_pkg::*;
#(
    parameter int SAMPLE_PERIOD_BITS     = 6,
    parameter int SAMPLES_PER_DIVISION   = 10,
    parameter int CLOCK_PERIOD_NS        = 10,
    parameter int TIME_PER_DIVISION_BITS = 10
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [SAMPLE_PERIOD_BITS-1:0]     samplePeriod,
    input  logic                              start,
    output logic                              ready,
    output logic                              done,
    output logic [TIME_PER_DIVISION_BITS-1:0] timePerDivision,
    output logic [1:0]                        unit,
    output logic                              overflow
);

    localparam int PRODUCT_BITS = SAMPLE_PERIOD_BITS + 1 +
                                  $clog2(SAMPLES_PER_DIVISION * CLOCK_PERIOD_NS);
    localparam int CW = (PRODUCT_BITS > TIME_PER_DIVISION_BITS) ?
                        PRODUCT_BITS : TIME_PER_DIVISION_BITS;

    state_e                          state, state_nx;
    logic [SAMPLE_PERIOD_BITS-1:0]   sp_q;
    logic [PRODUCT_BITS-1:0]         value, quotient;
    unit_e                           wunit;
    logic                            div_start, div_busy;
    logic [CW-1:0]                   value_ext;
    logic                            fits;

    assign value_ext = CW'(value);
    assign fits      = ((value_ext >> TIME_PER_DIVISION_BITS) == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        div_start = 1'b0;
        case (state)
            S_IDLE:      if (start) state_nx = S_MULTIPLY;
            S_MULTIPLY:  state_nx = S_NORMALIZE;
            S_NORMALIZE: begin
                if (value < PRODUCT_BITS'(DIVISOR) || wunit == UNIT_S) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx  = S_DIVIDE;
                    div_start = 1'b1;
                end
            end
            S_DIVIDE:    if (!div_busy) state_nx = S_NORMALIZE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp_q            <= '0;
            value           <= '0;
            wunit           <= UNIT_NS;
            timePerDivision <= '0;
            unit            <= '0;
            overflow        <= 1'b0;
        end else begin
            case (state)
                S_IDLE:     if (start) sp_q <= samplePeriod;
                S_MULTIPLY: begin
                    value <= (PRODUCT_BITS'(sp_q) + PRODUCT_BITS'(1)) *
                             PRODUCT_BITS'(SAMPLES_PER_DIVISION * CLOCK_PERIOD_NS);
                    wunit <= UNIT_NS;
                end
                S_NORMALIZE: begin
                    // results publish on the edge into DONE so they line up with done
                    if (state_nx == S_DONE) begin
                        timePerDivision <= fits ? value_ext[TIME_PER_DIVISION_BITS-1:0] : '1;
                        overflow        <= ~fits;
                        unit            <= wunit;
                    end
                end
                S_DIVIDE: begin
                    if (!div_busy) begin
                        value <= quotient;
                        wunit <= unit_e'(wunit + 2'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    serial_const_divider #(
        .WIDTH  (PRODUCT_BITS),
        .DIVISOR(DIVISOR)
    ) u_div (
        .clock   (clock),
        .reset   (reset),
        .start   (div_start),
        .dividend(value),
        .busy    (div_busy),
        .quotient(quotient)
    );

endmodule

// File: tb/tb_time_base_scaler.sv
// Bench for time_base_scaler: a default instance and an 8-bit mantissa
// instance share stimulus and are compared each cycle against a decade model.
module tb_time_base_scaler;

    logic       clock, reset, start;
    logic [5:0] samplePeriod;
    logic [1:0] rdy, dn, ovf;
    logic [9:0] tpd0;
    logic [7:0] tpd8;
    logic [1:0] un0, un8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    time_base_scaler dut (
        .clock(clock), .reset(reset), .samplePeriod(samplePeriod), .start(start),
        .ready(rdy[0]), .done(dn[0]), .timePerDivision(tpd0), .unit(un0), .overflow(ovf[0])
    );

    time_base_scaler #(.TIME_PER_DIVISION_BITS(8)) dut8 (
        .clock(clock), .reset(reset), .samplePeriod(samplePeriod), .start(start),
        .ready(rdy[1]), .done(dn[1]), .timePerDivision(tpd8), .unit(un8), .overflow(ovf[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // result of one conversion from arithmetic on the nanosecond value
    function automatic void calc(input int sp, input int tbits, output int tpd,
                                 output int un, output int ov, output int lat);
        int v, k;
        v = (sp + 1) * 10 * 10;
        k = 0;
        while (v >= 1000 && k < 3) begin
            v = v / 1000;
            k++;
        end
        if (v >= (1 << tbits)) begin
            tpd = (1 << tbits) - 1;
            ov  = 1;
        end else begin
            tpd = v;
            ov  = 0;
        end
        un  = k;
        lat = 3 + 15 * k;
    endfunction

    bit m_ready[2], m_done[2];
    int m_tpd[2], m_unit[2], m_ovf[2], m_cnt[2];
    int p_tpd[2], p_unit[2], p_ovf[2];

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ready[i] = 1; m_done[i] = 0; m_cnt[i] = 0;
                m_tpd[i] = 0; m_unit[i] = 0; m_ovf[i] = 0;
            end else if (m_done[i]) begin
                m_done[i]  = 0;
                m_ready[i] = 1;
            end else if (m_ready[i]) begin
                if (start) begin
                    int lat;
                    calc(int'(samplePeriod), (i == 0) ? 10 : 8, p_tpd[i], p_unit[i], p_ovf[i], lat);
                    m_ready[i] = 0;
                    m_cnt[i]   = lat - 1;
                end
            end else begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_done[i] = 1;
                    m_tpd[i] = p_tpd[i]; m_unit[i] = p_unit[i]; m_ovf[i] = p_ovf[i];
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            logic [14:0] got [2];
            logic [14:0] exp [2];
            got[0] = {rdy[0], dn[0], tpd0, un0, ovf[0]};
            got[1] = {rdy[1], dn[1], 2'b00, tpd8, un8, ovf[1]};
            for (int i = 0; i < 2; i++) begin
                exp[i] = {m_ready[i], m_done[i], 10'(m_tpd[i]), 2'(m_unit[i]), 1'(m_ovf[i])};
                checks++;
                if (got[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL cycle_cmp[%0d] t=%0t got rdy/done/tpd/unit/ovf=%b/%b/%0d/%0d/%b exp %b/%b/%0d/%0d/%b",
                             i, $time, got[i][14], got[i][13], got[i][12:3], got[i][2:1], got[i][0],
                             exp[i][14], exp[i][13], exp[i][12:3], exp[i][2:1], exp[i][0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one start pulse; samplePeriod is scrambled after the start edge
    task automatic run(input int sp, input int elat, input int etpd, input int eun,
                       input int eov, input int etpd8, input int eov8);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        samplePeriod = 6'(sp);
        start = 1'b1;
        while (n < 200 && !seen) begin
            @(posedge clock);
            n++;
            #1;
            start = 1'b0;
            samplePeriod = 6'(~sp);
            if (dn[0] === 1'b1) seen = 1;
        end
        check($sformatf("latency sp=%0d", sp), seen ? n : -1, elat);
        check($sformatf("tpd sp=%0d", sp), int'(tpd0), etpd);
        check($sformatf("unit sp=%0d", sp), int'(un0), eun);
        check($sformatf("ovf sp=%0d", sp), int'(ovf[0]), eov);
        check($sformatf("tpd8 sp=%0d", sp), int'(tpd8), etpd8);
        check($sformatf("ovf8 sp=%0d", sp), int'(ovf[1]), eov8);
        tick();
    endtask

    initial begin
        int t, u, o, l, cnt;
        reset = 1'b1;
        start = 1'b0;
        samplePeriod = '0;
        #2;
        chk_en = 1;

        calc(0, 10, t, u, o, l);
        check("model sp0 tpd", t, 100); check("model sp0 lat", l, 3);
        calc(63, 10, t, u, o, l);
        check("model sp63 tpd", t, 6); check("model sp63 unit", u, 1); check("model sp63 lat", l, 18);
        calc(2, 8, t, u, o, l);
        check("model sp2 w8 tpd", t, 255); check("model sp2 w8 ovf", o, 1);

        tick(); tick();
        check("reset ready", int'(rdy[0]), 1);
        check("reset done", int'(dn[0]), 0);
        check("reset tpd", int'(tpd0), 0);
        reset = 1'b0;

        run(0, 3, 100, 0, 0, 100, 0);
        run(9, 18, 1, 1, 0, 1, 0);
        run(63, 18, 6, 1, 0, 6, 0);
        run(2, 3, 300, 0, 0, 255, 1);
        run(31, 18, 3, 1, 0, 3, 0);
        repeat (5) tick();

        // start held high through a whole conversion
        samplePeriod = 6'd9;
        start = 1'b1;
        cnt = 0;
        repeat (18) begin
            tick();
            if (dn[0] === 1'b1) cnt++;
        end
        start = 1'b0;
        repeat (40) begin
            tick();
            if (dn[0] === 1'b1) cnt++;
        end
        check("held start dones", cnt, 1);

        // reset in the middle of a divide
        samplePeriod = 6'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        #1;
        check("midreset ready", int'(rdy[0]), 1);
        check("midreset done", int'(dn[0]), 0);
        check("midreset tpd", int'(tpd0), 0);
        check("midreset unit", int'(un0), 0);
        check("midreset ovf8", int'(ovf[1]), 0);
        tick();
        reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            tick();
            if (dn[0] === 1'b1) cnt++;
        end
        check("post-reset no done", cnt, 0);
        run(0, 3, 100, 0, 0, 100, 0);
        repeat (3) tick();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
